// File: rtl/alu_op_sequencer.sv
// Hardwired T0-T6 control sequencer for register-register ALU instructions with a start/done
// handshake to the multi-cycle MUL/DIV unit. Optional watchdog in T4W: define SEQ_TIMEOUT_EN.
module alu_op_sequencer #(
  parameter int unsigned MEM_WAIT = 1,
  parameter logic [4:0]  OP_ADD   = 5'b00011,
  parameter logic [4:0]  OP_SUB   = 5'b00100,
  parameter logic [4:0]  OP_AND   = 5'b00101,
  parameter logic [4:0]  OP_OR    = 5'b00110,
  parameter logic [4:0]  OP_MUL   = 5'b01000,
  parameter logic [4:0]  OP_DIV   = 5'b01001,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Run,
  input  logic [31:0] IR,
  input  logic        AluDone,
  output logic        PCout,
  output logic        ZLowout,
  output logic        ZHighout,
  output logic        MDRout,
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        HIin,
  output logic        LOin,
  output logic        IncPC,
  output logic        Read,
  output logic [15:0] Rout,
  output logic [15:0] Rin,
  output logic [4:0]  AluOp,
  output logic        AluStart,
  output logic        Busy,
  output logic        InstrDone,
  output logic        IllegalOp,
  output logic        Fault
);

  localparam int unsigned WAIT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

  typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T4W, T5, T6} state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                fault_q;

  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       is_single, is_multi, is_legal;
  logic       unused_ir;

  assign opcode    = IR[31:27];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  assign unused_ir = ^IR[14:0];
  assign is_single = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                     (opcode == OP_AND) || (opcode == OP_OR);
  assign is_multi  = (opcode == OP_MUL) || (opcode == OP_DIV);
  assign is_legal  = is_single || is_multi;

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            fault_d;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      to_cnt_q <= '0;
      fault_q  <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      fault_q  <= fault_d;
    end
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign fault_q        = 1'b0;
`endif

  assign Fault = fault_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
`ifdef SEQ_TIMEOUT_EN
    to_cnt_d   = '0;
    fault_d    = fault_q;
`endif
    case (state_q)
      IDLE: if (Run && !fault_q) state_d = T0;
      T0:   state_d = T1;
      T1: begin
        if (wait_cnt_q == WAIT_W'(MEM_WAIT - 1)) state_d = T2;
        else wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      end
      T2:   state_d = T3;
      T3:   state_d = is_legal ? T4 : (Run ? T0 : IDLE);
      T4:   state_d = is_multi ? T4W : T5;
      T4W: begin
        if (AluDone) state_d = T5;
`ifdef SEQ_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          state_d = IDLE;
          fault_d = 1'b1;
        end else to_cnt_d = to_cnt_q + TO_W'(1);
`endif
      end
      T5:      state_d = is_multi ? T6 : (Run ? T0 : IDLE);
      T6:      state_d = Run ? T0 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes decode the registered state; only Zin in T4W follows AluDone in the same cycle.
  always_comb begin
    PCout = 1'b0; ZLowout = 1'b0; ZHighout = 1'b0; MDRout = 1'b0;
    MARin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0;
    Zin = 1'b0; HIin = 1'b0; LOin = 1'b0; IncPC = 1'b0; Read = 1'b0;
    Rout = '0; Rin = '0; AluOp = '0; AluStart = 1'b0;
    InstrDone = 1'b0; IllegalOp = 1'b0;
    Busy = (state_q != IDLE);
    case (state_q)
      T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
      end
      T1: begin
        ZLowout = 1'b1; Read = 1'b1; MDRin = 1'b1;
        PCin    = (wait_cnt_q == '0);
      end
      T2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      T3: begin
        if (is_legal) begin
          Rout = 16'h0001 << rb;
          Yin  = 1'b1;
        end else IllegalOp = 1'b1;
      end
      T4: begin
        Rout     = 16'h0001 << rc;
        AluOp    = opcode;
        Zin      = is_single;
        AluStart = is_multi;
      end
      T4W: begin
        Rout  = 16'h0001 << rc;
        AluOp = opcode;
        Zin   = AluDone;
      end
      T5: begin
        ZLowout = 1'b1;
        if (is_multi) LOin = 1'b1;
        else begin
          Rin       = 16'h0001 << ra;
          InstrDone = 1'b1;
        end
      end
      T6: begin
        ZHighout = 1'b1; HIin = 1'b1; InstrDone = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: per-cycle strobe vectors checked against hand-computed
// constants. The watchdog scenario runs only when SEQ_TIMEOUT_EN is defined.
module tb_alu_op_sequencer;

  logic        Clock = 1'b0;
  logic        Reset, Run, AluDone;
  logic [31:0] IR;
  logic        PCout, ZLowout, ZHighout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zin;
  logic        HIin, LOin, IncPC, Read, AluStart, Busy, InstrDone, IllegalOp, Fault;
  logic [15:0] Rout, Rin;
  logic [4:0]  AluOp;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  localparam logic [18:0] PCOUT = 19'h00001, ZLOWOUT = 19'h00002, ZHIGHOUT = 19'h00004,
                          MDROUT = 19'h00008, MARIN = 19'h00010, PCIN = 19'h00020,
                          MDRIN = 19'h00040, IRIN = 19'h00080, YIN = 19'h00100,
                          ZIN = 19'h00200, HIIN = 19'h00400, LOIN = 19'h00800,
                          INCPC = 19'h01000, READ = 19'h02000, ALUSTART = 19'h04000,
                          BUSY = 19'h08000, INSTRDONE = 19'h10000, ILLEGAL = 19'h20000,
                          FAULT = 19'h40000;

  localparam logic [31:0] IR_ADD = 32'h1A920000;  // ADD R5,R2,R4
  localparam logic [31:0] IR_DIV = 32'h4A920000;  // DIV R5,R2,R4
  localparam logic [31:0] IR_SUB = 32'h20888000;  // SUB R1,R1,R1
  localparam logic [31:0] IR_BAD = 32'hF8000000;  // opcode 5'b11111

  alu_op_sequencer #(.MEM_WAIT(1), .TIMEOUT(8)) dut (
    .Clock(Clock), .Reset(Reset), .Run(Run), .IR(IR), .AluDone(AluDone),
    .PCout(PCout), .ZLowout(ZLowout), .ZHighout(ZHighout), .MDRout(MDRout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read), .Rout(Rout), .Rin(Rin),
    .AluOp(AluOp), .AluStart(AluStart), .Busy(Busy), .InstrDone(InstrDone),
    .IllegalOp(IllegalOp), .Fault(Fault)
  );

  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [55:0] observed();
    return {AluOp, Rout, Rin, Fault, IllegalOp, InstrDone, Busy, AluStart, Read, IncPC,
            LOin, HIin, Zin, Yin, IRin, MDRin, PCin, MARin, MDRout, ZHighout, ZLowout, PCout};
  endfunction

  task automatic check(input string tag, input logic [55:0] got, input logic [55:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [18:0] s, input logic [15:0] ro,
                     input logic [15:0] ri, input logic [4:0] op);
    @(negedge Clock);
    check(tag, observed(), {op, ro, ri, s});
  endtask

  task automatic fetch(input string tag);
    cyc({tag, "_t0"}, PCOUT | MARIN | INCPC | ZIN | BUSY, 16'h0, 16'h0, 5'd0);
    cyc({tag, "_t1"}, ZLOWOUT | PCIN | READ | MDRIN | BUSY, 16'h0, 16'h0, 5'd0);
    cyc({tag, "_t2"}, MDROUT | IRIN | BUSY, 16'h0, 16'h0, 5'd0);
  endtask

  initial begin
    Reset = 1'b1; Run = 1'b0; AluDone = 1'b0; IR = '0;
    repeat (2) @(posedge Clock);
    cyc("reset", 19'h0, 16'h0, 16'h0, 5'd0);
    Reset = 1'b0;

    // ADD R5,R2,R4 with Run dropped during fetch
    IR = IR_ADD; Run = 1'b1;
    fetch("add");
    Run = 1'b0;
    cyc("add_t3", YIN | BUSY, 16'h0004, 16'h0, 5'd0);
    cyc("add_t4", ZIN | BUSY, 16'h0010, 16'h0, 5'd3);
    cyc("add_t5", ZLOWOUT | INSTRDONE | BUSY, 16'h0, 16'h0020, 5'd0);
    cyc("add_idle", 19'h0, 16'h0, 16'h0, 5'd0);

    // DIV with AluDone five cycles after AluStart; AluDone in T4 must not raise Zin
    IR = IR_DIV; Run = 1'b1;
    fetch("div");
    Run = 1'b0;
    cyc("div_t3", YIN | BUSY, 16'h0004, 16'h0, 5'd0);
    cyc("div_t4", ALUSTART | BUSY, 16'h0010, 16'h0, 5'd9);
    AluDone = 1'b1; #1;
    check("div_t4_done_ignored", observed(), {5'd9, 16'h0010, 16'h0, ALUSTART | BUSY});
    AluDone = 1'b0;
    for (int i = 1; i <= 4; i++)
      cyc($sformatf("div_t4w%0d", i), BUSY, 16'h0010, 16'h0, 5'd9);
    @(negedge Clock);
    AluDone = 1'b1; #1;
    check("div_t4w5_zin", observed(), {5'd9, 16'h0010, 16'h0, ZIN | BUSY});
    cyc("div_t5", ZLOWOUT | LOIN | BUSY, 16'h0, 16'h0, 5'd0);
    AluDone = 1'b0;
    cyc("div_t6", ZHIGHOUT | HIIN | INSTRDONE | BUSY, 16'h0, 16'h0, 5'd0);
    cyc("div_idle", 19'h0, 16'h0, 16'h0, 5'd0);

    // Illegal opcode: Run=1 returns to T0, Run=0 returns to IDLE
    IR = IR_BAD; Run = 1'b1;
    fetch("bad1");
    cyc("bad1_t3", ILLEGAL | BUSY, 16'h0, 16'h0, 5'd0);
    fetch("bad2");
    Run = 1'b0;
    cyc("bad2_t3", ILLEGAL | BUSY, 16'h0, 16'h0, 5'd0);
    cyc("bad_idle", 19'h0, 16'h0, 16'h0, 5'd0);

    // Back-to-back ADD then SUB R1,R1,R1; Run drops mid second instruction
    IR = IR_ADD; Run = 1'b1;
    fetch("b2b1");
    cyc("b2b1_t3", YIN | BUSY, 16'h0004, 16'h0, 5'd0);
    cyc("b2b1_t4", ZIN | BUSY, 16'h0010, 16'h0, 5'd3);
    cyc("b2b1_t5", ZLOWOUT | INSTRDONE | BUSY, 16'h0, 16'h0020, 5'd0);
    fetch("b2b2");
    IR = IR_SUB; Run = 1'b0;
    cyc("b2b2_t3", YIN | BUSY, 16'h0002, 16'h0, 5'd0);
    cyc("b2b2_t4", ZIN | BUSY, 16'h0002, 16'h0, 5'd4);
    cyc("b2b2_t5", ZLOWOUT | INSTRDONE | BUSY, 16'h0, 16'h0002, 5'd0);
    cyc("b2b_idle", 19'h0, 16'h0, 16'h0, 5'd0);

    // Reset in T4W mid-DIV; later AluDone has no effect
    IR = IR_DIV; Run = 1'b1;
    fetch("rst");
    Run = 1'b0;
    cyc("rst_t3", YIN | BUSY, 16'h0004, 16'h0, 5'd0);
    cyc("rst_t4", ALUSTART | BUSY, 16'h0010, 16'h0, 5'd9);
    cyc("rst_t4w1", BUSY, 16'h0010, 16'h0, 5'd9);
    cyc("rst_t4w2", BUSY, 16'h0010, 16'h0, 5'd9);
    Reset = 1'b1;
    cyc("rst_cleared", 19'h0, 16'h0, 16'h0, 5'd0);
    Reset = 1'b0; AluDone = 1'b1;
    cyc("rst_done_ign1", 19'h0, 16'h0, 16'h0, 5'd0);
    cyc("rst_done_ign2", 19'h0, 16'h0, 16'h0, 5'd0);
    AluDone = 1'b0;

`ifdef SEQ_TIMEOUT_EN
    // Watchdog: DIV never completes, TIMEOUT=8
    IR = IR_DIV; Run = 1'b1;
    fetch("to");
    Run = 1'b0;
    cyc("to_t3", YIN | BUSY, 16'h0004, 16'h0, 5'd0);
    cyc("to_t4", ALUSTART | BUSY, 16'h0010, 16'h0, 5'd9);
    for (int i = 1; i <= 8; i++)
      cyc($sformatf("to_t4w%0d", i), BUSY, 16'h0010, 16'h0, 5'd9);
    cyc("to_fault", FAULT, 16'h0, 16'h0, 5'd0);
    Run = 1'b1;
    for (int i = 1; i <= 3; i++)
      cyc($sformatf("to_run_ign%0d", i), FAULT, 16'h0, 16'h0, 5'd0);
    Reset = 1'b1;
    cyc("to_reset", 19'h0, 16'h0, 16'h0, 5'd0);
    Reset = 1'b0; Run = 1'b0;
    cyc("to_idle", 19'h0, 16'h0, 16'h0, 5'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
